cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Merges the core's instruction-fetch and data-memory cbus requests onto the single cbus that feeds the MMU.
- Grants one requester at a time and holds a registered, stable copy of its request on the downstream port until the transaction finishes.
- Routes the downstream response back to the granted requester only.
- Sits directly upstream of the mmu block; its oreq drives the MMU ireq, and the MMU iresp drives its oresp.

Parameters:
- NUM_PORTS, 2, number of upstream requesters; port 0 is ifetch, port 1 is dmem. Legal range 2..8.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- ireqs  input  NUM_PORTS x cbus_req_t  upstream requests (valid, is_write, size, addr, strobe, data, len, burst).
- iresps  output  NUM_PORTS x cbus_resp_t  upstream responses (ready, last, data).
- oreq  output  cbus_req_t  request to the MMU.
- oresp  input  cbus_resp_t  response from the MMU.

Behaviour:
- Reset values (reset low, asynchronous):
  - state=IDLE, grant index=0, round-robin pointer=0.
  - oreq='0, so oreq.valid=0.
  - Every iresps[i] is combinationally '0 while state!=BUSY.
- State IDLE:
  - If any ireqs[i].valid=1, select a winner per the grant policy.
  - On the clock edge: latch the winner index, latch the full ireqs[winner] into oreq with valid=1, go to BUSY.
  - Latency from ireq.valid to oreq.valid is exactly 1 cycle.
  - If no request is valid, stay in IDLE with oreq.valid=0.
- State BUSY:
  - oreq holds the latched copy. Later changes, or withdrawal of ireqs[grant], have no effect on oreq.
  - iresps[grant] = oresp combinationally (ready, last and data pass through unmodified). All other iresps = '0.
  - oresp.ready=1 with last=0 (burst beat): forward the beat and stay in BUSY.
  - oresp.ready=1 with last=1: clear oreq.valid on the edge (other oreq fields may keep their values), go to GAP.
- State GAP:
  - Lasts one cycle. oreq.valid=0 and all iresps='0.
  - Then go to IDLE; no new grant is issued in GAP.
  - The cycle lets the requester drop valid and lets the MMU return to its idle state.
- Requests that arrive while in BUSY or GAP wait. A requester keeps valid high until it sees ready and last.
- Default grant policy: fixed priority, the lowest-index valid port wins.
- Simultaneous events:
  - A completion (ready and last) and new requests in the same cycle produce no grant that cycle.
  - The minimum gap between two consecutive oreq.valid rises is 2 cycles.
- Reset going low in BUSY: oreq.valid=0 and iresps='0 asynchronously. The transaction is abandoned with no response beat.
- Width rule: the grant index is clog2(NUM_PORTS) bits. Indices >= NUM_PORTS are never produced.

Optional Feature:
- Macro: CBUS_ARB_RR_EN
- Defined: round-robin policy.
  - The pointer holds (last granted + 1) mod NUM_PORTS and updates whenever a grant is issued.
  - The search starts at the pointer and wraps around.
  - With all ports continuously valid, each is granted once per NUM_PORTS transactions.
- Undefined: fixed-priority policy as above; the pointer logic is removed.

Test Plan:
- Single read: ireqs[0] valid, addr=0x8000_0000, size=MSIZE8, len=MLEN1. Response: oreq.valid=1 with identical fields 1 cycle later. Then drive oresp ready=1, last=1, data=0xDEAD_BEEF. Response: iresps[0].data=0xDEAD_BEEF in that cycle, iresps[1]='0, oreq.valid=0 next cycle.
- Write pass-through: ireqs[1] is_write=1, strobe=0x0F, data=0x1234, port 0 idle. Response: oreq carries strobe=0x0F, data=0x1234 exactly, and iresps[0] stays '0 throughout.
- Contention, fixed priority: both ports valid in the same cycle. Response: port 0 is served first; port 1's oreq.valid rises exactly 2 cycles after port 0's last beat.
- Contention with CBUS_ARB_RR_EN defined: both ports held valid for 4 transactions. Response: grant order 0,1,0,1.
- Burst: len=MLEN4; oresp gives 3 beats with last=0, then 1 with last=1. Response: all 4 beats appear on iresps[grant], and the arbiter stays in BUSY until the 4th.
- Reset mid-transaction: reset driven low while in BUSY. Response: oreq.valid=0 in the same cycle. After reset rises, an ireqs[1] request is granted normally.

Source files
------------

// File: rtl/cbus_pkg.sv
// Shared cbus payload types and encodings used between the core, the arbiter and the MMU.
package cbus_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [3:0]        len;
    logic [1:0]        burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges NUM_PORTS upstream cbus requesters (0 = ifetch, 1 = dmem) onto the
// single cbus feeding the MMU. One transaction at a time; the granted request is held in a
// register until its last beat, followed by a one-cycle gap before the next grant.
// Build option: define CBUS_ARB_RR_EN for round-robin grant; otherwise the lowest valid
// port index wins.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_PORTS],
  output cbus_resp_t iresps [NUM_PORTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             any_valid;
  cbus_req_t        win_req;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  // Pick the winning requester; the search order depends on the grant policy
  always_comb begin
    win       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
`ifdef CBUS_ARB_RR_EN
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_PORTS);
`else
      cand = IDX_W'(k);
`endif
      if (!any_valid && ireqs[cand].valid) begin
        win       = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Copy of the winning request as it will be presented downstream
  always_comb begin
    win_req       = ireqs[win];
    win_req.valid = 1'b1;
  end

  // Grant FSM with the registered downstream request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      oreq   <= '0;
`ifdef CBUS_ARB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state  <= BUSY;
            grant  <= win;
            oreq   <= win_req;
`ifdef CBUS_ARB_RR_EN
            rr_ptr <= IDX_W'((32'(win) + 32'd1) % NUM_PORTS);
`endif
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state      <= GAP;
            oreq.valid <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Route the MMU response to the granted requester only, and only while a transaction is open
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
      if (state == BUSY && grant == IDX_W'(i)) begin
        iresps[i] = oresp;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios with literal expectations, then
// randomized requesters and MMU checked every cycle against a transaction-level model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NP = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [NP];
  cbus_resp_t iresps [NP];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  cbus_arbiter #(.NUM_PORTS(NP)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: who owns the bus, whether we are in the post-completion
  // quiet cycle, the request captured at grant time, and where round-robin starts.
  int        m_owner;
  bit        m_gap;
  cbus_req_t m_held;
  int        m_next;
  int        m_beats;
  bit        done_i  [NP];
  bit        waiting [NP];
  int        grant_log[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_held  = '0;
    m_next  = 0;
    m_beats = 0;
    for (int i = 0; i < NP; i++) done_i[i] = 1'b0;
  endtask

  // Priority rank of a port: smaller wins
  function automatic int rank(input int p);
`ifdef CBUS_ARB_RR_EN
    return (p + NP - m_next) % NP;
`else
    return p;
`endif
  endfunction

  function automatic int m_pick();
    int best;
    best = -1;
    for (int p = 0; p < NP; p++)
      if (ireqs[p].valid && (best < 0 || rank(p) < rank(best))) best = p;
    return best;
  endfunction

  // Advance the model across one rising edge using the inputs present before the edge
  task automatic model_step();
    int w;
    for (int i = 0; i < NP; i++) done_i[i] = 1'b0;
    if (!reset) begin
      m_reset();
      return;
    end
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner >= 0) begin
      if (oresp.ready) m_beats--;
      if (oresp.ready && oresp.last) begin
        done_i[m_owner] = 1'b1;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else begin
      w = m_pick();
      if (w >= 0) begin
        m_owner      = w;
        m_held       = ireqs[w];
        m_held.valid = 1'b1;
        m_next       = (w + 1) % NP;
        m_beats      = int'(m_held.len) + 1;
        grant_log.push_back(w);
      end
    end
  endtask

  task automatic compare_all();
    cbus_resp_t exp;
    chk("oreq.valid", 160'(oreq.valid), 160'(m_owner >= 0));
    if (m_owner >= 0) chk("oreq", 160'(oreq), 160'(m_held));
    for (int i = 0; i < NP; i++) begin
      exp = (m_owner == i) ? oresp : '0;
      chk($sformatf("iresps[%0d]", i), 160'(iresps[i]), 160'(exp));
    end
  endtask

  // One clock: check at the falling edge, step the model at the rising edge, return just after it
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    for (int p = 0; p < NP; p++) ireqs[p] = '0;
    oresp = '0;
  endtask

  function automatic cbus_req_t mk_req(input logic [63:0] addr, input logic wr,
                                       input logic [7:0] strb, input logic [63:0] data,
                                       input logic [3:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = MSIZE8;
    r.addr     = addr;
    r.strobe   = strb;
    r.data     = data;
    r.len      = len;
    r.burst    = BURST_INCR;
    return r;
  endfunction

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.size     = 3'($urandom_range(0, 3));
    r.addr     = {$urandom, $urandom};
    r.strobe   = 8'($urandom);
    r.data     = {$urandom, $urandom};
    r.burst    = 2'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       r.len = MLEN1;
      1:       r.len = MLEN2;
      default: r.len = MLEN4;
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int waited;
    int exp_order [4];

    // Reset: outputs quiet even with a live-looking MMU response
    reset = 1'b0;
    drive_idle();
    m_reset();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'hFFFF;
    tick();
    tick();
    chk("rst oreq.valid", 160'(oreq.valid), 160'(1'b0));
    chk("rst iresps[0]", 160'(iresps[0]), 160'(0));
    chk("rst iresps[1]", 160'(iresps[1]), 160'(0));
    reset = 1'b1;
    oresp = '0;
    tick();

    // Single read
    ireqs[0] = mk_req(64'h8000_0000, 1'b0, 8'hFF, 64'h0, MLEN1);
    tick();
    chk("read oreq.valid", 160'(oreq.valid), 160'(1'b1));
    chk("read oreq.addr", 160'(oreq.addr), 160'(64'h8000_0000));
    chk("read oreq.size", 160'(oreq.size), 160'(MSIZE8));
    chk("read oreq.len", 160'(oreq.len), 160'(MLEN1));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'hDEAD_BEEF;
    #1;
    chk("read iresps[0].data", 160'(iresps[0].data), 160'(64'hDEAD_BEEF));
    chk("read iresps[0].last", 160'(iresps[0].last), 160'(1'b1));
    chk("read iresps[1]", 160'(iresps[1]), 160'(0));
    tick();
    drive_idle();
    #1;
    chk("read oreq.valid after last", 160'(oreq.valid), 160'(1'b0));
    tick();
    tick();

    // Write pass-through on port 1
    ireqs[1] = mk_req(64'h1000, 1'b1, 8'h0F, 64'h1234, MLEN1);
    tick();
    chk("write oreq.valid", 160'(oreq.valid), 160'(1'b1));
    chk("write oreq.is_write", 160'(oreq.is_write), 160'(1'b1));
    chk("write oreq.strobe", 160'(oreq.strobe), 160'(8'h0F));
    chk("write oreq.data", 160'(oreq.data), 160'(64'h1234));
    oresp.data = 64'h55;
    #1;
    chk("write iresps[1].data", 160'(iresps[1].data), 160'(64'h55));
    chk("write iresps[0] wait", 160'(iresps[0]), 160'(0));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    #1;
    chk("write iresps[0] last", 160'(iresps[0]), 160'(0));
    tick();
    drive_idle();
    tick();
    tick();

    // Contention: port 0 first, port 1 follows after exactly two idle cycles
    ireqs[0] = mk_req(64'h100, 1'b0, 8'hFF, 64'h0, MLEN1);
    ireqs[1] = mk_req(64'h200, 1'b0, 8'hFF, 64'h0, MLEN1);
    tick();
    chk("contend first addr", 160'(oreq.addr), 160'(64'h100));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    tick();
    ireqs[0] = '0;
    oresp    = '0;
    low = 0;
    while (oreq.valid !== 1'b1 && low < 10) begin
      low++;
      tick();
    end
    chk("contend idle cycles", 160'(low), 160'(2));
    chk("contend second addr", 160'(oreq.addr), 160'(64'h200));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    tick();
    drive_idle();
    tick();
    tick();

    // Burst of four beats
    ireqs[0] = mk_req(64'h3000, 1'b0, 8'hFF, 64'h0, MLEN4);
    tick();
    for (int b = 0; b < 4; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == 3);
      oresp.data  = 64'hB000 + 64'(b);
      #1;
      chk($sformatf("burst beat %0d data", b), 160'(iresps[0].data), 160'(64'hB000 + 64'(b)));
      chk($sformatf("burst beat %0d busy", b), 160'(oreq.valid), 160'(1'b1));
      tick();
    end
    drive_idle();
    #1;
    chk("burst done valid", 160'(oreq.valid), 160'(1'b0));
    tick();
    tick();

    // Reset in the middle of a transaction, then a normal grant to port 1
    ireqs[0] = mk_req(64'h5000, 1'b0, 8'hFF, 64'h0, MLEN4);
    tick();
    oresp.ready = 1'b1;
    oresp.last  = 1'b0;
    oresp.data  = 64'h77;
    #1;
    reset = 1'b0;
    m_reset();
    #1;
    chk("midrst oreq.valid", 160'(oreq.valid), 160'(1'b0));
    chk("midrst iresps[0]", 160'(iresps[0]), 160'(0));
    drive_idle();
    tick();
    reset = 1'b1;
    ireqs[1] = mk_req(64'h4000, 1'b0, 8'hFF, 64'h0, MLEN1);
    tick();
    chk("postrst oreq.valid", 160'(oreq.valid), 160'(1'b1));
    chk("postrst oreq.addr", 160'(oreq.addr), 160'(64'h4000));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    #1;
    chk("postrst iresps[1].ready", 160'(iresps[1].ready), 160'(1'b1));
    tick();
    drive_idle();
    tick();
    tick();

    // Both ports continuously valid for four transactions
`ifdef CBUS_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    ireqs[0] = mk_req(64'h0000, 1'b0, 8'hFF, 64'h0, MLEN1);
    ireqs[1] = mk_req(64'h0100, 1'b0, 8'hFF, 64'h0, MLEN1);
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      while (oreq.valid !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      if (waited >= 10) begin
        n_cmp++;
        n_bad++;
        $display("FAIL order wait %0d: no grant within %0d cycles", t, waited);
      end
      chk($sformatf("order[%0d]", t), 160'(oreq.addr[8]), 160'(exp_order[t]));
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      tick();
      oresp = '0;
    end
    drive_idle();
    tick();
    tick();

    // Randomized traffic checked every cycle by the model
    for (int p = 0; p < NP; p++) waiting[p] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (done_i[p]) begin
          ireqs[p]   = '0;
          waiting[p] = 1'b0;
        end
        if (!waiting[p] && $urandom_range(0, 3) == 0) begin
          ireqs[p]   = rand_req();
          waiting[p] = 1'b1;
        end else if (waiting[p]) begin
          ireqs[p].data = {$urandom, $urandom};
          ireqs[p].addr = {$urandom, $urandom};
          if (m_owner == p && $urandom_range(0, 7) == 0) ireqs[p].valid = 1'b0;
        end
      end
      oresp.data = {$urandom, $urandom};
      if (m_owner >= 0) begin
        oresp.ready = 1'($urandom_range(0, 1));
        oresp.last  = oresp.ready && (m_beats == 1);
      end else begin
        oresp.ready = 1'($urandom_range(0, 1));
        oresp.last  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    drive_idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
